// File: rtl/bsg_gateway_chip_io_link_loopback_tester.sv
// Loopback traffic endpoint: sends seed+k packets on a ready_and link and checks the returned stream in order.
// Latency: TX data is registered state, RX is checked in the cycle of transfer; v never depends on the incoming ready.
module bsg_gateway_chip_io_link_loopback_tester #(
    parameter int width_p           = 32,
    parameter int num_packets_p     = 256,
    parameter int max_outstanding_p = 16,
    parameter int timeout_p         = 4096,
    localparam int link_sif_width_lp = width_p + 2,
    localparam int cnt_w_lp          = $clog2(num_packets_p + 1)
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         start_i,
    input  logic [width_p-1:0]           seed_i,
    input  logic                         rx_stall_i,
    input  logic [link_sif_width_lp-1:0] link_i,
    output logic [link_sif_width_lp-1:0] link_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         pass_o,
    output logic                         timeout_o,
    output logic [15:0]                  error_count_o,
    output logic [cnt_w_lp-1:0]          sent_count_o,
    output logic [cnt_w_lp-1:0]          recv_count_o,
    output logic [width_p-1:0]           first_err_data_o
);
    localparam int tmo_w_lp = $clog2(timeout_p + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_DRAIN, ST_DONE} state_e;

    state_e               state_q, state_d;
    logic [width_p-1:0]   seed_q, seed_d;
    logic [cnt_w_lp-1:0]  sent_q, sent_d, recv_q, recv_d;
    logic [tmo_w_lp-1:0]  tmo_q, tmo_d;
    logic                 timeout_q, timeout_d;
    logic [15:0]          err_q, err_d;
    logic [width_p-1:0]   first_err_q, first_err_d;

    logic                 tx_v, tx_fire, rx_rdy, rx_fire, active;
    logic [31:0]          outstanding;
    logic [width_p-1:0]   tx_data, rx_data, rx_exp;

    always_comb begin
        active      = (state_q == ST_SEND) || (state_q == ST_DRAIN);
        outstanding = 32'(sent_q - recv_q);
        // Counters only move on transfers, so v cannot fall before its own transfer.
        tx_v        = (state_q == ST_SEND) && (sent_q < cnt_w_lp'(num_packets_p))
                      && (outstanding < 32'(max_outstanding_p));
        tx_data     = seed_q + width_p'(sent_q);
        tx_fire     = tx_v && link_i[0];
        rx_rdy      = active && !rx_stall_i && (recv_q < sent_q);
        rx_data     = link_i[width_p:1];
        rx_fire     = link_i[width_p+1] && rx_rdy;
        rx_exp      = seed_q + width_p'(recv_q);
    end

    always_comb begin
        state_d     = state_q;
        seed_d      = seed_q;
        sent_d      = sent_q;
        recv_d      = recv_q;
        tmo_d       = tmo_q;
        timeout_d   = timeout_q;
        err_d       = err_q;
        first_err_d = first_err_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d     = ST_SEND;
                    seed_d      = seed_i;
                    sent_d      = '0;
                    recv_d      = '0;
                    tmo_d       = '0;
                    timeout_d   = 1'b0;
                    err_d       = '0;
                    first_err_d = '0;
                end
            end
            default: begin
                if (tx_fire) begin
                    sent_d = sent_q + cnt_w_lp'(1);
                    if (sent_q == cnt_w_lp'(num_packets_p - 1)) state_d = ST_DRAIN;
                end
                if (rx_fire) begin
                    recv_d = recv_q + cnt_w_lp'(1);
                    if (rx_data != rx_exp) begin
                        if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
                        if (err_q == 16'd0) first_err_d = rx_data;
                    end
                    if (state_q == ST_DRAIN && recv_q == cnt_w_lp'(num_packets_p - 1)) state_d = ST_DONE;
                end
                // Idle watchdog: only runs while words are owed back and none arrive.
                if (rx_fire || recv_q == sent_q) begin
                    tmo_d = '0;
                end else if (tmo_q == tmo_w_lp'(timeout_p - 1)) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + tmo_w_lp'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= ST_IDLE;
            seed_q      <= '0;
            sent_q      <= '0;
            recv_q      <= '0;
            tmo_q       <= '0;
            timeout_q   <= 1'b0;
            err_q       <= '0;
            first_err_q <= '0;
        end else begin
            state_q     <= state_d;
            seed_q      <= seed_d;
            sent_q      <= sent_d;
            recv_q      <= recv_d;
            tmo_q       <= tmo_d;
            timeout_q   <= timeout_d;
            err_q       <= err_d;
            first_err_q <= first_err_d;
        end
    end

    assign link_o           = {tx_v, (tx_v ? tx_data : {width_p{1'b0}}), rx_rdy};
    assign busy_o           = active;
    assign done_o           = (state_q == ST_DONE);
    assign pass_o           = (state_q == ST_DONE) && (err_q == 16'd0) && !timeout_q;
    assign timeout_o        = timeout_q;
    assign error_count_o    = err_q;
    assign sent_count_o     = sent_q;
    assign recv_count_o     = recv_q;
    assign first_err_data_o = first_err_q;
endmodule

// File: tb/tb_bsg_gateway_chip_io_link_loopback_tester.sv
// Bench: loopback path modelled as an 8-deep FIFO with optional corruption, cut and random ready.
module tb_bsg_gateway_chip_io_link_loopback_tester;
    localparam int W   = 32;
    localparam int NP  = 8;
    localparam int MO  = 4;
    localparam int TMO = 120;
    localparam int CW  = $clog2(NP + 1);

    logic          clk = 0;
    logic          rst_n = 0;
    logic          start = 0;
    logic [W-1:0]  seed = 0;
    logic          stall = 0;
    logic [W+1:0]  link_i, link_o;
    logic          busy, done, pass, tmo;
    logic [15:0]   errc;
    logic [CW-1:0] sentc, recvc;
    logic [W-1:0]  first_err;

    int total = 0;
    int bad = 0;

    bsg_gateway_chip_io_link_loopback_tester #(
        .width_p(W), .num_packets_p(NP), .max_outstanding_p(MO), .timeout_p(TMO)
    ) dut (
        .clk_i(clk), .reset_n_i(rst_n), .start_i(start), .seed_i(seed), .rx_stall_i(stall),
        .link_i(link_i), .link_o(link_o), .busy_o(busy), .done_o(done), .pass_o(pass),
        .timeout_o(tmo), .error_count_o(errc), .sent_count_o(sentc), .recv_count_o(recvc),
        .first_err_data_o(first_err)
    );

    always #5 clk = ~clk;

    logic         dut_v, dut_rdy;
    logic [W-1:0] dut_dat;
    assign dut_v   = link_o[W+1];
    assign dut_dat = link_o[W:1];
    assign dut_rdy = link_o[0];

    // Return path model
    logic [W-1:0] fq [8];
    logic [2:0]   wr, rd;
    int           fcnt, rx_idx;
    logic         rnd_bit;
    logic         lb_clr = 0;
    logic         rnd_en = 0;
    int           xor_idx = -1;
    int           ret_limit = -1;
    logic         lb_v, lb_rdy;
    logic [W-1:0] lb_dat;

    always_comb begin
        lb_v   = (fcnt != 0) && (ret_limit < 0 || rx_idx < ret_limit);
        lb_dat = fq[rd] ^ ((rx_idx == xor_idx) ? 32'h1 : 32'h0);
        lb_rdy = (fcnt < 8) && (!rnd_en || rnd_bit);
    end
    assign link_i = {lb_v, lb_dat, lb_rdy};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || lb_clr) begin
            wr <= 0; rd <= 0; fcnt <= 0; rx_idx <= 0; rnd_bit <= 1'b1;
        end else begin
            if (dut_v && lb_rdy) begin
                fq[wr] <= dut_dat;
                wr     <= wr + 3'd1;
            end
            if (lb_v && dut_rdy) begin
                rd     <= rd + 3'd1;
                rx_idx <= rx_idx + 1;
            end
            fcnt    <= fcnt + ((dut_v && lb_rdy) ? 1 : 0) - ((lb_v && dut_rdy) ? 1 : 0);
            rnd_bit <= 1'($urandom);
        end
    end

    // Observation: logs every accepted TX word and flags v/data changes while stalled.
    int           cyc = 0;
    logic [W-1:0] tx_log [$];
    int           stab_err = 0;
    int           last_rx_cyc = 0;
    logic         pend = 0;
    logic [W-1:0] pend_dat = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (pend && !(dut_v && dut_dat == pend_dat)) stab_err = stab_err + 1;
            if (dut_v && lb_rdy) tx_log.push_back(dut_dat);
            if (lb_v && dut_rdy) last_rx_cyc = cyc;
            pend     = dut_v && !lb_rdy;
            pend_dat = dut_dat;
        end else begin
            pend = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [W-1:0] s);
        lb_clr = 1;
        tick();
        lb_clr = 0;
        seed  = s;
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic wait_done(input int budget, output bit ok, output int when);
        ok = 0;
        when = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1;
                when = cyc;
                break;
            end
        end
    endtask

    task automatic check_seq(input string name, input int base, input logic [W-1:0] s);
        total++;
        if (tx_log.size() - base !== NP) begin
            bad++;
            $display("FAIL %s tx_count: got %0d want %0d", name, tx_log.size() - base, NP);
        end
        for (int k = 0; k < NP && base + k < tx_log.size(); k++) begin
            logic [W-1:0] want;
            want = s + W'(k);
            total++;
            if (tx_log[base + k] !== want) begin
                bad++;
                $display("FAIL %s tx_data[%0d]: got %h want %h", name, k, tx_log[base + k], want);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (3) @(negedge clk);
        total++;
        if (link_o !== '0 || busy !== 0 || done !== 0 || pass !== 0) begin
            bad++;
            $display("FAIL reset_link: got link=%h busy=%b done=%b pass=%b want all 0", link_o, busy, done, pass);
        end
        total++;
        if (sentc !== 0 || recvc !== 0 || errc !== 0 || tmo !== 0 || first_err !== 0) begin
            bad++;
            $display("FAIL reset_status: got sent=%0d recv=%0d err=%0d tmo=%b ferr=%h want 0",
                     sentc, recvc, errc, tmo, first_err);
        end
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic test_ideal();
        bit ok; int when; int base;
        base = tx_log.size();
        start_run(32'h10);
        wait_done(500, ok, when);
        total++;
        if (!ok) begin bad++; $display("FAIL ideal_done: got done=0 want 1"); end
        check_seq("ideal", base, 32'h10);
        total++;
        if (pass !== 1 || errc !== 0 || sentc !== NP || recvc !== NP || tmo !== 0) begin
            bad++;
            $display("FAIL ideal_status: got pass=%b err=%0d sent=%0d recv=%0d tmo=%b want 1 0 8 8 0",
                     pass, errc, sentc, recvc, tmo);
        end
    endtask

    task automatic test_corrupt();
        bit ok; int when;
        xor_idx = 3;
        start_run(32'h0);
        wait_done(500, ok, when);
        xor_idx = -1;
        total++;
        if (!ok) begin bad++; $display("FAIL corrupt_done: got done=0 want 1"); end
        total++;
        if (errc !== 1) begin bad++; $display("FAIL corrupt_errc: got %0d want 1", errc); end
        total++;
        if (first_err !== 32'h2) begin bad++; $display("FAIL corrupt_first: got %h want 2", first_err); end
        total++;
        if (pass !== 0) begin bad++; $display("FAIL corrupt_pass: got %b want 0", pass); end
    endtask

    task automatic test_stall();
        bit ok; int when; int base;
        logic [W-1:0] s;
        s = 32'hFFFF_FFFE;
        base = tx_log.size();
        stall = 1;
        start_run(s);
        repeat (100) tick();
        total++;
        if (sentc !== MO || dut_v !== 0 || recvc !== 0 || busy !== 1) begin
            bad++;
            $display("FAIL stall_cap: got sent=%0d v=%b recv=%0d busy=%b want 4 0 0 1", sentc, dut_v, recvc, busy);
        end
        stall = 0;
        wait_done(500, ok, when);
        total++;
        if (!ok || pass !== 1 || tmo !== 0 || errc !== 0) begin
            bad++;
            $display("FAIL stall_finish: got done=%b pass=%b tmo=%b err=%0d want 1 1 0 0", ok, pass, tmo, errc);
        end
        check_seq("stall", base, s);
    endtask

    task automatic test_cut();
        bit ok; int when;
        ret_limit = 2;
        start_run(W'($urandom));
        wait_done(600, ok, when);
        ret_limit = -1;
        total++;
        if (!ok) begin bad++; $display("FAIL cut_done: got done=0 want 1"); end
        total++;
        if (when - last_rx_cyc - 1 !== TMO) begin
            bad++;
            $display("FAIL cut_idle: got %0d idle cycles want %0d", when - last_rx_cyc - 1, TMO);
        end
        total++;
        if (tmo !== 1 || pass !== 0 || recvc !== 2) begin
            bad++;
            $display("FAIL cut_status: got tmo=%b pass=%b recv=%0d want 1 0 2", tmo, pass, recvc);
        end
    endtask

    task automatic test_random_ready();
        bit ok; int when; int base; int sbase;
        logic [W-1:0] s;
        s = W'($urandom);
        base = tx_log.size();
        sbase = stab_err;
        rnd_en = 1;
        start_run(s);
        wait_done(3000, ok, when);
        rnd_en = 0;
        total++;
        if (!ok) begin bad++; $display("FAIL rnd_done: got done=0 want 1"); end
        total++;
        if (stab_err - sbase !== 0) begin
            bad++;
            $display("FAIL rnd_stable: got %0d v/data changes while stalled want 0", stab_err - sbase);
        end
        check_seq("rnd", base, s);
        total++;
        if (pass !== 1 || sentc !== NP || recvc !== NP) begin
            bad++;
            $display("FAIL rnd_status: got pass=%b sent=%0d recv=%0d want 1 8 8", pass, sentc, recvc);
        end
    endtask

    task automatic test_reset_mid();
        bit ok; int when; int base;
        logic [W-1:0] s;
        start_run(W'($urandom));
        repeat (3) tick();
        total++;
        if (busy !== 1) begin bad++; $display("FAIL mid_busy: got %b want 1", busy); end
        rst_n = 0;
        @(negedge clk);
        total++;
        if (link_o !== '0 || busy !== 0 || done !== 0 || pass !== 0 || sentc !== 0 || recvc !== 0
            || errc !== 0 || first_err !== 0 || tmo !== 0) begin
            bad++;
            $display("FAIL mid_reset: got link=%h busy=%b done=%b sent=%0d recv=%0d want all 0",
                     link_o, busy, done, sentc, recvc);
        end
        tick();
        rst_n = 1;
        tick();
        s = W'($urandom);
        base = tx_log.size();
        start_run(s);
        wait_done(500, ok, when);
        total++;
        if (!ok || pass !== 1 || sentc !== NP || recvc !== NP) begin
            bad++;
            $display("FAIL mid_rerun: got done=%b pass=%b sent=%0d recv=%0d want 1 1 8 8", ok, pass, sentc, recvc);
        end
        check_seq("rerun", base, s);
    endtask

    initial begin
        test_reset();
        test_ideal();
        test_corrupt();
        test_stall();
        test_cut();
        test_random_ready();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
